// File: rtl/flaf_tap_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : flaf_tap_scheduler
// Purpose  : Time-multiplexed tap controller for an adaptive FIR filter.
//            One shared multiply/round unit serves NTAPS taps. Per sample the
//            block runs a filtering pass (sum of x[k]*w[k]), emits a saturated
//            output, waits for the scaled error term mu*e, then runs a weight
//            update pass w[k] += round(mu*e * x[k]) over all taps.
// Ports    : clk        - clock
//            reset      - synchronous, active-high reset
//            in_valid   - new sample offered       in_ready  - sample accepted (IDLE)
//            x_in       - input sample (Q(QP))
//            y_valid    - one-cycle output strobe  y_out     - saturated filter output
//            err_valid  - mu*error offered         err_ready - error accepted (WAIT_ERR)
//            mu_err     - mu*error term (Q(QP))
//            busy       - high while filtering or updating
//            tap_idx    - tap currently processed (debug)
// Options  : define FLAF_SAT_WEIGHT_EN to saturate weight updates instead of
//            letting them wrap modulo 2^WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module flaf_tap_scheduler #(
   parameter int WIDTH = 16,
   parameter int QP    = 12,
   parameter int NTAPS = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x_in,
   output logic             y_valid,
   output logic [WIDTH-1:0] y_out,
   input  logic             err_valid,
   output logic             err_ready,
   input  logic [WIDTH-1:0] mu_err,
   output logic             busy,
   output logic [AW-1:0]    tap_idx
);

   localparam int ACCW = WIDTH + AW;
   localparam int PW   = 2 * WIDTH;

   localparam logic signed [PW-1:0] c_RND_HALF = PW'(1) << (QP - 1);
   localparam logic [AW-1:0]        c_LAST_TAP = AW'(NTAPS - 1);
   localparam logic [WIDTH-1:0]     c_Y_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0]     c_Y_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FILTER   = 2'd1,
      S_WAIT_ERR = 2'd2,
      S_UPDATE   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [AW-1:0]           idx_q, idx_d;
   logic signed [ACCW-1:0]  acc_q, acc_d;
   logic [WIDTH-1:0]        x_q   [NTAPS];
   logic [WIDTH-1:0]        x_d   [NTAPS];
   logic [WIDTH-1:0]        wgt_q [NTAPS];
   logic [WIDTH-1:0]        wgt_d [NTAPS];
   logic [WIDTH-1:0]        mu_q, mu_d;
   logic [WIDTH-1:0]        y_out_q, y_out_d;
   logic                    y_valid_q, y_valid_d;

   // ---------------------------------------------------------------------
   // Shared multiply/round unit. The second operand is the tap weight while
   // filtering and the latched mu*error term while updating.
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0]        w_mul_a;
   logic [WIDTH-1:0]        w_mul_b;
   logic signed [PW-1:0]    w_prod;
   logic signed [PW-1:0]    w_prod_rnd;
   logic [WIDTH-1:0]        w_term;
   logic                    w_unused_rnd;
   logic [ACCW-1:0]         w_acc_sum;
   logic [AW:0]             w_acc_hi;
   logic [WIDTH-1:0]        w_y_sat;
   logic [WIDTH-1:0]        w_wgt_new;

   always_comb begin
      w_mul_a    = x_q[idx_q];
      w_mul_b    = (state_q == S_UPDATE) ? mu_q : wgt_q[idx_q];
      w_prod     = $signed(w_mul_a) * $signed(w_mul_b);
      // Round half up, then drop the QP fractional bits.
      w_prod_rnd = w_prod + c_RND_HALF;
      w_term     = w_prod_rnd[QP +: WIDTH];
   end

   // Fractional and overflow bits of the rounded product are discarded.
   assign w_unused_rnd = ^w_prod_rnd;

   // Accumulator grows by AW bits so NTAPS full-scale terms never overflow.
   assign w_acc_sum = acc_q + {{AW{w_term[WIDTH-1]}}, w_term};
   assign w_acc_hi  = w_acc_sum[ACCW-1:WIDTH-1];

   // Result fits in WIDTH bits only when all bits from WIDTH-1 up agree.
   always_comb begin
      if ((w_acc_hi == {(AW+1){1'b0}}) || (w_acc_hi == {(AW+1){1'b1}})) begin
         w_y_sat = w_acc_sum[WIDTH-1:0];
      end else if (w_acc_sum[ACCW-1]) begin
         w_y_sat = c_Y_MIN;
      end else begin
         w_y_sat = c_Y_MAX;
      end
   end

`ifdef FLAF_SAT_WEIGHT_EN
   logic [WIDTH:0] w_wgt_sum;
   assign w_wgt_sum = {wgt_q[idx_q][WIDTH-1], wgt_q[idx_q]} + {w_term[WIDTH-1], w_term};
   // Overflow when the extended sign bit disagrees with the WIDTH-bit sign.
   always_comb begin
      if (w_wgt_sum[WIDTH] == w_wgt_sum[WIDTH-1]) begin
         w_wgt_new = w_wgt_sum[WIDTH-1:0];
      end else if (w_wgt_sum[WIDTH]) begin
         w_wgt_new = c_Y_MIN;
      end else begin
         w_wgt_new = c_Y_MAX;
      end
   end
`else
   assign w_wgt_new = wgt_q[idx_q] + w_term;
`endif

   // ---------------------------------------------------------------------
   // Next-state and datapath control
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      x_d       = x_q;
      wgt_d     = wgt_q;
      mu_d      = mu_q;
      y_out_d   = y_out_q;
      y_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               for (int k = NTAPS - 1; k > 0; k--) begin
                  x_d[k] = x_q[k-1];
               end
               x_d[0]  = x_in;
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_FILTER;
            end
         end

         S_FILTER: begin
            acc_d = w_acc_sum;
            idx_d = idx_q + 1'b1;
            if (idx_q == c_LAST_TAP) begin
               y_out_d   = w_y_sat;
               y_valid_d = 1'b1;
               idx_d     = '0;
               state_d   = S_WAIT_ERR;
            end
         end

         S_WAIT_ERR: begin
            if (err_valid) begin
               mu_d    = mu_err;
               idx_d   = '0;
               state_d = S_UPDATE;
            end
         end

         S_UPDATE: begin
            wgt_d[idx_q] = w_wgt_new;
            idx_d        = idx_q + 1'b1;
            if (idx_q == c_LAST_TAP) begin
               idx_d   = '0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         acc_q     <= '0;
         mu_q      <= '0;
         y_out_q   <= '0;
         y_valid_q <= 1'b0;
         for (int k = 0; k < NTAPS; k++) begin
            x_q[k]   <= '0;
            wgt_q[k] <= '0;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         mu_q      <= mu_d;
         y_out_q   <= y_out_d;
         y_valid_q <= y_valid_d;
         x_q       <= x_d;
         wgt_q     <= wgt_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign err_ready = (state_q == S_WAIT_ERR);
   assign busy      = (state_q == S_FILTER) || (state_q == S_UPDATE);
   assign tap_idx   = idx_q;
   assign y_out     = y_out_q;
   assign y_valid   = y_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_flaf_tap_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_flaf_tap_scheduler
// Purpose  : Self-checking bench for flaf_tap_scheduler. A reference model
//            keeps the delay line and weights as integer arrays and computes
//            outputs and updates with plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flaf_tap_scheduler;

   localparam int WIDTH = 16;
   localparam int QP    = 12;
   localparam int NTAPS = 8;
   localparam int AW    = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x_in;
   logic             y_valid;
   logic [WIDTH-1:0] y_out;
   logic             err_valid;
   logic             err_ready;
   logic [WIDTH-1:0] mu_err;
   logic             busy;
   logic [AW-1:0]    tap_idx;

   int n_cmp  = 0;
   int n_fail = 0;

   int mx [NTAPS];
   int mw [NTAPS];

   flaf_tap_scheduler #(
      .WIDTH (WIDTH),
      .QP    (QP),
      .NTAPS (NTAPS),
      .AW    (AW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .y_valid   (y_valid),
      .y_out     (y_out),
      .err_valid (err_valid),
      .err_ready (err_ready),
      .mu_err    (mu_err),
      .busy      (busy),
      .tap_idx   (tap_idx)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   function automatic int wrap16(longint v);
      logic [15:0] t;
      t = v[15:0];
      return int'($signed(t));
   endfunction

   function automatic int sat16(longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   // Q(QP) product, rounded half up, kept to WIDTH bits.
   function automatic int rnd_term(int a, int b);
      longint p;
      p = longint'(a) * longint'(b) + longint'(1 << (QP - 1));
      return wrap16(p >>> QP);
   endfunction

   function automatic void m_reset();
      for (int k = 0; k < NTAPS; k++) begin
         mx[k] = 0;
         mw[k] = 0;
      end
   endfunction

   function automatic void m_shift(logic [15:0] x);
      for (int k = NTAPS - 1; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = int'($signed(x));
   endfunction

   function automatic logic [15:0] m_filter();
      longint s;
      int     r;
      logic [15:0] y;
      s = 0;
      for (int k = 0; k < NTAPS; k++) s += rnd_term(mx[k], mw[k]);
      r = sat16(s);
      y = r[15:0];
      return y;
   endfunction

   function automatic void m_update(logic [15:0] mu);
      int     m;
      longint s;
      m = int'($signed(mu));
      for (int k = 0; k < NTAPS; k++) begin
         s = longint'(mw[k]) + longint'(rnd_term(m, mx[k]));
`ifdef FLAF_SAT_WEIGHT_EN
         mw[k] = sat16(s);
`else
         mw[k] = wrap16(s);
`endif
      end
   endfunction

   // ------------------------------------------------------------------
   // One full sample period. Optionally drives in_valid/err_valid noise
   // while those handshakes must be ignored.
   // ------------------------------------------------------------------
   task automatic do_sample(input logic [15:0] x, input logic [15:0] mu, input bit noise,
                            input int err_wait, output logic [15:0] y_obs);
      logic [15:0] exp_y;
      logic [3:0]  exp_ctl;
      int          guard;
      y_obs = 'x;
      guard = 0;
      while (in_ready !== 1'b1 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL in_ready_wait: in_ready=%b, required 1 within 100 cycles", in_ready);
      end
      in_valid = 1'b1;
      x_in     = x;
      @(posedge clk); #1;
      m_shift(x);
      exp_y = m_filter();
      // FILTER cycles 1..NTAPS, then the y_valid cycle NTAPS+1
      for (int c = 1; c <= NTAPS + 1; c++) begin
         in_valid  = 1'b0;
         err_valid = 1'b0;
         if (noise && c <= NTAPS) begin
            in_valid  = 1'b1;
            x_in      = 16'($urandom);
            err_valid = 1'b1;
            mu_err    = 16'($urandom);
         end
         // {busy, y_valid, in_ready, err_ready}
         exp_ctl = (c <= NTAPS) ? 4'b1000 : 4'b0101;
         n_cmp++;
         if ({busy, y_valid, in_ready, err_ready} !== exp_ctl) begin
            n_fail++;
            $display("FAIL filter_ctl_c%0d: {busy,y_valid,in_ready,err_ready}=%b required %b",
                     c, {busy, y_valid, in_ready, err_ready}, exp_ctl);
         end
         if (c <= NTAPS) begin
            n_cmp++;
            if (tap_idx !== AW'(c - 1)) begin
               n_fail++;
               $display("FAIL filter_tap_idx_c%0d: got %0d required %0d", c, tap_idx, c - 1);
            end
            @(posedge clk); #1;
         end else begin
            y_obs = y_out;
            n_cmp++;
            if (y_out !== exp_y) begin
               n_fail++;
               $display("FAIL y_out: got %h required %h", y_out, exp_y);
            end
         end
      end
      // WAIT_ERR hold cycles
      for (int w = 0; w < err_wait; w++) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({busy, y_valid, in_ready, err_ready, y_out} !== {4'b0001, exp_y}) begin
            n_fail++;
            $display("FAIL wait_err_hold: ctl=%b y_out=%h required ctl=0001 y_out=%h",
                     {busy, y_valid, in_ready, err_ready}, y_out, exp_y);
         end
      end
      err_valid = 1'b1;
      mu_err    = mu;
      @(posedge clk); #1;
      m_update(mu);
      for (int u = 0; u < NTAPS; u++) begin
         in_valid  = 1'b0;
         err_valid = 1'b0;
         if (noise) begin
            in_valid  = 1'b1;
            x_in      = 16'($urandom);
            err_valid = 1'b1;
            mu_err    = 16'($urandom);
         end
         n_cmp++;
         if ({busy, y_valid, in_ready, err_ready, tap_idx} !== {4'b1000, AW'(u)}) begin
            n_fail++;
            $display("FAIL update_ctl_u%0d: ctl=%b tap_idx=%0d required ctl=1000 tap_idx=%0d",
                     u, {busy, y_valid, in_ready, err_ready}, tap_idx, u);
         end
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      err_valid = 1'b0;
      n_cmp++;
      if ({busy, in_ready, err_ready} !== 3'b010) begin
         n_fail++;
         $display("FAIL back_to_idle: {busy,in_ready,err_ready}=%b required 010",
                  {busy, in_ready, err_ready});
      end
   endtask

   task automatic apply_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      err_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      m_reset();
   endtask

   // ------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------
   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b1;
      err_valid = 1'b1;
      x_in      = 16'h1234;
      mu_err    = 16'h0800;
      repeat (3) begin @(posedge clk); #1; end
      in_valid  = 1'b0;
      err_valid = 1'b0;
      reset     = 1'b0;
      m_reset();
      n_cmp++;
      if ({busy, y_valid, in_ready, err_ready, tap_idx, y_out} !== {4'b0010, 3'd0, 16'h0000}) begin
         n_fail++;
         $display("FAIL reset_state: ctl=%b tap_idx=%0d y_out=%h required ctl=0010 tap_idx=0 y_out=0000",
                  {busy, y_valid, in_ready, err_ready}, tap_idx, y_out);
      end
   endtask

   task automatic test_zero_weights();
      logic [15:0] y;
      do_sample(16'd4096, 16'd0, 1'b0, 1, y);
      n_cmp++;
      if (y !== 16'h0000) begin
         n_fail++;
         $display("FAIL zero_weights: y_out=%h required 0000", y);
      end
   endtask

   task automatic test_single_tap();
      logic [15:0] y;
      apply_reset();
      do_sample(16'd2048, 16'd4096, 1'b0, 0, y);
      do_sample(16'd4096, 16'd0, 1'b0, 2, y);
      n_cmp++;
      if (y !== 16'd2048) begin
         n_fail++;
         $display("FAIL single_tap: y_out=%h required %h", y, 16'd2048);
      end
   endtask

   task automatic test_handshake();
      logic [15:0] y;
      for (int i = 0; i < 4; i++) begin
         do_sample(16'($urandom_range(0, 8191)), 16'($urandom_range(0, 1023)), 1'b1, i, y);
      end
   endtask

   task automatic test_output_saturation();
      logic [15:0] y;
      apply_reset();
      for (int i = 0; i < 8; i++) do_sample(16'd4096, 16'd0, 1'b0, 0, y);
      do_sample(16'd4096, 16'd4096, 1'b0, 0, y);
      for (int i = 0; i < 8; i++) do_sample(16'd16384, 16'd0, 1'b0, 0, y);
      n_cmp++;
      if (y !== 16'h7FFF) begin
         n_fail++;
         $display("FAIL sat_positive: y_out=%h required 7fff", y);
      end
      for (int i = 0; i < 8; i++) do_sample(16'hC000, 16'd0, 1'b0, 0, y);
      n_cmp++;
      if (y !== 16'h8000) begin
         n_fail++;
         $display("FAIL sat_negative: y_out=%h required 8000", y);
      end
   endtask

   task automatic test_reset_mid_filter();
      logic [15:0] y;
      int          pulses;
      in_valid = 1'b1;
      x_in     = 16'd4096;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++;
      if (tap_idx !== 3'd3) begin
         n_fail++;
         $display("FAIL mid_filter_idx: tap_idx=%0d required 3", tap_idx);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_reset();
      n_cmp++;
      if ({busy, y_valid, in_ready, err_ready, tap_idx, y_out} !== {4'b0010, 3'd0, 16'h0000}) begin
         n_fail++;
         $display("FAIL mid_filter_reset: ctl=%b tap_idx=%0d y_out=%h required ctl=0010 tap_idx=0 y_out=0000",
                  {busy, y_valid, in_ready, err_ready}, tap_idx, y_out);
      end
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (y_valid === 1'b1) pulses++;
      end
      n_cmp++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL mid_filter_no_pulse: y_valid pulses=%0d required 0", pulses);
      end
      do_sample(16'($urandom), 16'd0, 1'b0, 0, y);
      n_cmp++;
      if (y !== 16'h0000) begin
         n_fail++;
         $display("FAIL post_reset_zero: y_out=%h required 0000", y);
      end
   endtask

   task automatic test_weight_overflow();
      logic [15:0] y;
      logic [15:0] exp_y;
      apply_reset();
      do_sample(16'd4096, 16'h7000, 1'b0, 0, y);
      do_sample(16'd4096, 16'h2000, 1'b0, 0, y);
      n_cmp++;
      if (y !== 16'h7000) begin
         n_fail++;
         $display("FAIL overflow_setup: y_out=%h required 7000", y);
      end
      // x[0..2]=4096, w[1]=0x2000; w[0] is either wrapped (0x9000) or 0x7FFF
      do_sample(16'd4096, 16'd0, 1'b0, 0, y);
`ifdef FLAF_SAT_WEIGHT_EN
      exp_y = 16'h7FFF;
`else
      exp_y = 16'hB000;
`endif
      n_cmp++;
      if (y !== exp_y) begin
         n_fail++;
         $display("FAIL weight_overflow: y_out=%h required %h", y, exp_y);
      end
   endtask

   task automatic test_random();
      logic [15:0] y;
      logic [15:0] mu;
      apply_reset();
      for (int i = 0; i < 24; i++) begin
         mu = 16'($urandom_range(0, 2047)) - 16'd1024;
         do_sample(16'($urandom), mu, 1'($urandom), int'($urandom_range(0, 3)), y);
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      err_valid = 1'b0;
      x_in      = '0;
      mu_err    = '0;
      m_reset();
      #1;
      test_reset();
      test_zero_weights();
      test_single_tap();
      test_handshake();
      test_output_saturation();
      test_reset_mid_filter();
      test_weight_overflow();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
